// File: rtl/wb_ram_slave.sv
// Wishbone B3 classic slave in front of a single-port synchronous RAM (one-cycle read latency).
// Define WB_RAM_SLAVE_ADDR_CHECK_EN to terminate requests outside the RAM window with err.
module wb_ram_slave #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_adr_o,
    output logic [3:0]        ram_be_o,
    output logic [31:0]       ram_dat_o,
    input  logic [31:0]       ram_dat_i
);

    // state | meaning
    // IDLE  | waiting for a request; a write hits the RAM on the edge leaving IDLE
    // RD    | RAM sampled the address, read data is valid at the end of this cycle
    // ACK   | wb_ack_o high for exactly this cycle
    // ERR   | wb_err_o high for exactly this cycle (address-checked builds only)
    typedef enum logic [1:0] {IDLE, RD, ACK, ERR} state_t;

    state_t state_q, state_d;
    logic   req;
    logic   hit;

    assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_RAM_SLAVE_ADDR_CHECK_EN
    // BASE_ADDR is aligned to the window size, so a tag compare is an exact range check.
    assign hit = (wb_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    logic unused_adr;
    assign unused_adr = ^wb_adr_i[1:0];
`else
    assign hit = 1'b1;
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0], BASE_ADDR};
`endif

    assign ram_adr_o = wb_adr_i[ADDR_W+1:2];
    assign ram_be_o  = wb_sel_i;
    assign ram_dat_o = wb_dat_i;
    assign ram_we_o  = rst_n_i & (state_q == IDLE) & req & wb_we_i & hit;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (!hit)        state_d = ERR;
                    else if (wb_we_i) state_d = ACK;
                    else             state_d = RD;
                end
            end
            RD:      state_d = wb_cyc_i ? ACK : IDLE;
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            state_q  <= state_d;
            wb_ack_o <= (state_d == ACK);
            // An aborted read (cyc dropped in RD) leaves the previous read data in place.
            if (state_q == RD && wb_cyc_i)
                wb_dat_o <= ram_dat_i;
        end
    end

`ifdef WB_RAM_SLAVE_ADDR_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) wb_err_o <= 1'b0;
        else          wb_err_o <= (state_d == ERR);
    end
`else
    assign wb_err_o = 1'b0;
`endif

endmodule
